// File: rtl/injection_monitor_pkg.sv
// Shared definitions for the injection monitor: result class codes and the
// observer FSM state encoding.
package injection_pkg;

    localparam logic [1:0] CLS_MASKED     = 2'd0;
    localparam logic [1:0] CLS_TRANSIENT  = 2'd1;
    localparam logic [1:0] CLS_PERSISTENT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OBSERVE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

endpackage

// File: rtl/injection_monitor_cmp.sv
// injection_cmp: per-output compare of faulty vs reference copy.
// Keeps a sticky mismatch mask and latches the observe-cycle index of the
// first mismatch. The *_nxt outputs already include the current cycle so the
// owner can capture a complete result on the final window cycle.
// Ports:
//   clk, rstn            clock, async active-low reset
//   i_clr                clear mask and first-hit flag (start of a run)
//   i_en                 accumulate this cycle
//   i_cyc                current observe-cycle index
//   i_y1/y2_dut/ref      compared signals
//   o_mis                {y2,y1} mismatch this cycle
//   o_mask_nxt           sticky mask including this cycle
//   o_lat_nxt            first-mismatch index including this cycle, all-ones if none
module injection_cmp #(
    parameter int LAT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [LAT_W-1:0] i_cyc,
    input  logic             i_y1_dut,
    input  logic             i_y2_dut,
    input  logic             i_y1_ref,
    input  logic             i_y2_ref,
    output logic [1:0]       o_mis,
    output logic [1:0]       o_mask_nxt,
    output logic [LAT_W-1:0] o_lat_nxt
);

    logic [1:0]       r_mask;
    logic             r_hit;
    logic [LAT_W-1:0] r_lat;
    logic [1:0]       w_mis;

    assign w_mis      = {i_y2_dut ^ i_y2_ref, i_y1_dut ^ i_y1_ref};
    assign o_mis      = w_mis;
    assign o_mask_nxt = r_mask | w_mis;
    assign o_lat_nxt  = r_hit ? r_lat : ((|w_mis) ? i_cyc : {LAT_W{1'b1}});

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mask <= 2'b00;
            r_hit  <= 1'b0;
            r_lat  <= '0;
        end else if (i_clr) begin
            r_mask <= 2'b00;
            r_hit  <= 1'b0;
            r_lat  <= '0;
        end else if (i_en) begin
            r_mask <= r_mask | w_mis;
            if (!r_hit && (|w_mis)) begin
                r_hit <= 1'b1;
                r_lat <= i_cyc;
            end
        end
    end

endmodule

// File: rtl/injection_monitor.sv
// injection_monitor: observes a faulty and a reference injection_module over a
// fixed window per run, classifies the run (MASKED / TRANSIENT / PERSISTENT),
// returns the result over valid/ready and counts non-masked runs (saturating).
// Ports:
//   clk, rstn             clock, async active-low reset
//   start, abort          run control
//   y1/y2_dut, y1/y2_ref  compared signals
//   busy                  high in OBSERVE and REPORT
//   res_valid, res_ready  result handshake
//   res_class/mask/lat    result fields, stable while res_valid
//   err_cnt               accepted non-masked results, saturating
module injection_monitor
    import injection_pkg::*;
#(
    parameter int OBS_CYCLES = 64,
    parameter int LAT_W      = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             y1_dut,
    input  logic             y2_dut,
    input  logic             y1_ref,
    input  logic             y2_ref,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_class,
    output logic [1:0]       res_mask,
    output logic [LAT_W-1:0] res_lat,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CYC_W = $clog2(OBS_CYCLES + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [1:0]         r_class;
    logic [1:0]         r_mask;
    logic [LAT_W-1:0]   r_lat;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_run_start;
    logic               w_win_end;
    logic               w_accept;
    logic               w_cmp_en;
    logic [1:0]         w_mis;
    logic [1:0]         w_mask_nxt;
    logic [LAT_W-1:0]   w_lat_nxt;

    // abort overrides start, window end and handshake alike
    assign w_run_start = (r_state == ST_IDLE) && start && !abort;
    assign w_win_end   = (r_state == ST_OBSERVE) && !abort &&
                         (r_cyc == CYC_W'(OBS_CYCLES - 1));
    assign w_accept    = (r_state == ST_REPORT) && res_ready && !abort;
    assign w_cmp_en    = (r_state == ST_OBSERVE) && !abort;

    injection_cmp #(
        .LAT_W (LAT_W)
    ) u_cmp (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_run_start),
        .i_en       (w_cmp_en),
        .i_cyc      (LAT_W'(r_cyc)),
        .i_y1_dut   (y1_dut),
        .i_y2_dut   (y2_dut),
        .i_y1_ref   (y1_ref),
        .i_y2_ref   (y2_ref),
        .o_mis      (w_mis),
        .o_mask_nxt (w_mask_nxt),
        .o_lat_nxt  (w_lat_nxt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run_start) w_state_nxt = ST_OBSERVE;
            end
            ST_OBSERVE: begin
                if (abort)          w_state_nxt = ST_IDLE;
                else if (w_win_end) w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (abort || w_accept) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cyc     <= '0;
            r_class   <= CLS_MASKED;
            r_mask    <= 2'b00;
            r_lat     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_run_start) begin
                r_cyc <= '0;
            end else if (w_cmp_en) begin
                r_cyc <= r_cyc + CYC_W'(1);
            end

            // final cycle's mismatch is folded in via the *_nxt values
            if (w_win_end) begin
                r_mask <= w_mask_nxt;
                r_lat  <= w_lat_nxt;
                if (|w_mis)           r_class <= CLS_PERSISTENT;
                else if (|w_mask_nxt) r_class <= CLS_TRANSIENT;
                else                  r_class <= CLS_MASKED;
            end

            if (w_accept && (r_class != CLS_MASKED) &&
                (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign res_valid = (r_state == ST_REPORT);
    assign res_class = r_class;
    assign res_mask  = r_mask;
    assign res_lat   = r_lat;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_injection_monitor.sv
module tb_injection_monitor;

    localparam int OBS = 8;
    localparam int LW  = 8;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          y1_dut = 1'b0, y2_dut = 1'b0, y1_ref = 1'b0, y2_ref = 1'b0;
    logic          busy, res_valid;
    logic          res_ready = 1'b0;
    logic [1:0]    res_class, res_mask;
    logic [LW-1:0] res_lat;
    logic [CW-1:0] err_cnt;

    injection_monitor #(.OBS_CYCLES(OBS), .LAT_W(LW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .y1_dut    (y1_dut),
        .y2_dut    (y2_dut),
        .y1_ref    (y1_ref),
        .y2_ref    (y2_ref),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_mask  (res_mask),
        .res_lat   (res_lat),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [1:0]    cls;
        logic [1:0]    mask;
        logic [LW-1:0] lat;
        int            edge_k;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_err  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // scoreboard monitor: checks each newly presented result against the queue
    logic mon_prev = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got res_valid=1 expected no result");
                end else begin
                    e = exp_q.pop_front();
                    check("valid_latency", cyc_cnt - e.edge_k, OBS);
                    check("res_class", {30'd0, res_class}, {30'd0, e.cls});
                    check("res_mask", {30'd0, res_mask}, {30'd0, e.mask});
                    check("res_lat", {24'd0, res_lat}, {24'd0, e.lat});
                end
            end
            mon_prev = res_valid;
        end
    end

    // one observation run; abort_at >= 0 aborts in that observe cycle
    task automatic run(input logic [7:0] inv1, input logic [7:0] inv2,
                       input logic [1:0] cls, input logic [1:0] mask,
                       input logic [LW-1:0] lat, input int abort_at);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        if (abort_at < 0) begin
            e.cls = cls; e.mask = mask; e.lat = lat; e.edge_k = cyc_cnt + 1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < OBS; i++) begin
            @(negedge clk);
            start  = 1'b0;
            y1_ref = 1'($urandom_range(1));
            y2_ref = 1'($urandom_range(1));
            y1_dut = y1_ref ^ inv1[i];
            y2_dut = y2_ref ^ inv2[i];
            if (i == abort_at) begin
                abort = 1'b1;
                break;
            end
        end
        @(negedge clk);
        abort  = 1'b0;
        y1_dut = y1_ref;
        y2_dut = y2_ref;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid_timeout", {31'd0, res_valid}, 32'd1);
    endtask

    // stall for `stall` cycles with start pulses, then accept with start also high
    task automatic handshake(input int stall, input logic [1:0] cls,
                             input logic [1:0] mask, input logic [LW-1:0] lat);
        wait_valid();
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            start = s[0];
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_class", {30'd0, res_class}, {30'd0, cls});
            check("stall_mask", {30'd0, res_mask}, {30'd0, mask});
            check("stall_lat", {24'd0, res_lat}, {24'd0, lat});
        end
        @(negedge clk);
        res_ready = 1'b1;
        start     = 1'b1;
        if (cls != 2'd0 && exp_err < 3) exp_err++;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check("post_hs_valid", {31'd0, res_valid}, 32'd0);
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        check("err_cnt", {30'd0, err_cnt}, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset and idle toggling
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_outputs", {busy, res_valid, res_class, res_mask, res_lat, err_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            y1_dut = i[0]; y2_dut = ~i[1]; y1_ref = i[1]; y2_ref = i[0];
            res_ready = i[0];
        end
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_toggle", {busy, res_valid, res_class, res_mask, res_lat, err_cnt}, 32'd0);

        // 2: clean run
        run(8'h00, 8'h00, 2'd0, 2'b00, 8'hFF, -1);
        handshake(0, 2'd0, 2'b00, 8'hFF);
        // 3: y1 mismatch in cycles 3-4
        run(8'b0001_1000, 8'h00, 2'd1, 2'b01, 8'd3, -1);
        handshake(0, 2'd1, 2'b01, 8'd3);
        // 4: y2 from cycle 5 to end, y1 in cycle 7
        run(8'b1000_0000, 8'b1110_0000, 2'd2, 2'b11, 8'd5, -1);
        handshake(0, 2'd2, 2'b11, 8'd5);
        // 5: stalled consumer, saturation
        run(8'h01, 8'h00, 2'd1, 2'b01, 8'd0, -1);
        handshake(5, 2'd1, 2'b01, 8'd0);
        run(8'h00, 8'h80, 2'd2, 2'b10, 8'd7, -1);
        handshake(0, 2'd2, 2'b10, 8'd7);
        run(8'h40, 8'h00, 2'd1, 2'b01, 8'd6, -1);
        handshake(0, 2'd1, 2'b01, 8'd6);

        // 6: abort in observe cycle 4
        run(8'h01, 8'h00, 2'd1, 2'b01, 8'd0, 4);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_valid", {31'd0, res_valid}, 32'd0);
        check("abort_err_cnt", {30'd0, err_cnt}, exp_err);
        // abort in IDLE blocks a simultaneous start
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_abort_blocks_start", {31'd0, busy}, 32'd0);

        // reset during REPORT
        run(8'h00, 8'h00, 2'd0, 2'b00, 8'hFF, -1);
        wait_valid();
        #1;
        rstn = 1'b0;
        #1;
        exp_err = 0;
        check("rst_in_report", {busy, res_valid, res_class, res_mask, res_lat, err_cnt}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_idle", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
